// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter into a single-ported data memory, formatting loads and merging sub-word stores.
// Latency from grant: load/word store 2, sub-word store 3, misaligned 1; each requester holds req until ack.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [1:0]  r0_size,
  input  logic        r0_unsigned,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  output logic        r0_err,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic        r1_err,
  output logic [31:0] r1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        gnt_q, we_q, uns_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] wdata_q;

  logic        any_req, sel, req_we, req_uns, misalign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt, merged;
  logic        sub_store;

  // sel=1 grants r1; on contention the port not granted last wins
  always_comb begin
    any_req   = r0_req | r1_req;
    sel       = (r0_req & r1_req) ? ~last_grant : r1_req;
    req_we    = sel ? r1_we    : r0_we;
    req_addr  = sel ? r1_addr  : r0_addr;
    req_size  = sel ? SZ_WORD  : r0_size;
    req_uns   = sel ? 1'b1     : r0_unsigned;
    req_wdata = sel ? r1_wdata : r0_wdata;
    misalign  = (req_size == 2'b11) ||
                ((req_size == SZ_HALF) && req_addr[0]) ||
                ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: load_fmt = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_fmt = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_fmt = mem_rdata;
    endcase
    merged = mem_rdata;
    if (size_q == SZ_BYTE)
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    sub_store = we_q && (size_q != SZ_WORD);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = misalign ? DONE : ACCESS;
      ACCESS:  state_nxt = sub_store ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst so an abandoned word store never reaches memory
  always_comb begin
    mem_we = ~rst && (((state == ACCESS) && we_q && (size_q == SZ_WORD)) || (state == WRITE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      wdata_q    <= 32'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      r0_ack     <= 1'b0;
      r0_err     <= 1'b0;
      r0_rdata   <= 32'd0;
      r1_ack     <= 1'b0;
      r1_err     <= 1'b0;
      r1_rdata   <= 32'd0;
    end else begin
      r0_ack <= 1'b0;
      r0_err <= 1'b0;
      r1_ack <= 1'b0;
      r1_err <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          gnt_q      <= sel;
          last_grant <= sel;
          we_q       <= req_we;
          uns_q      <= req_uns;
          size_q     <= req_size;
          lane_q     <= req_addr[1:0];
          wdata_q    <= req_wdata;
          if (misalign) begin
            if (sel) begin r1_ack <= 1'b1; r1_err <= 1'b1; end
            else     begin r0_ack <= 1'b1; r0_err <= 1'b1; end
          end else begin
            mem_addr <= {2'b00, req_addr[31:2]};
            if (req_we && (req_size == SZ_WORD)) mem_wdata <= req_wdata;
          end
        end
        ACCESS: begin
          if (sub_store) begin
            mem_wdata <= merged;
          end else begin
            if (gnt_q) r1_ack <= 1'b1;
            else       r0_ack <= 1'b1;
            if (!we_q) begin
              if (gnt_q) r1_rdata <= load_fmt;
              else       r0_rdata <= load_fmt;
            end
          end
        end
        WRITE: begin
          if (gnt_q) r1_ack <= 1'b1;
          else       r0_ack <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural word memory and ack/write scoreboards.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r0_unsigned;
  logic [31:0] r0_addr, r0_wdata;
  logic [1:0]  r0_size;
  logic        r0_ack, r0_err;
  logic [31:0] r0_rdata;
  logic        r1_req, r1_we;
  logic [31:0] r1_addr, r1_wdata;
  logic        r1_ack, r1_err;
  logic [31:0] r1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_size(r0_size),
    .r0_unsigned(r0_unsigned), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic err; logic chk; logic [31:0] rdata; } ack_exp_t;
  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_exp_t;

  ack_exp_t q0[$];
  ack_exp_t q1[$];
  wr_exp_t  qw[$];
  ack_exp_t m_e0, m_e1;
  wr_exp_t  m_w;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx;
  logic [31:0] pl_dat;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_dat;
  end
  assign mem_rdata = mem[mem_addr[3:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_ack(input int port, input int c, input logic err, input logic chk, input logic [31:0] rd);
    ack_exp_t e;
    e.cyc = c; e.err = err; e.chk = chk; e.rdata = rd;
    if (port == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic exp_wr(input int c, input logic [31:0] addr, input logic [31:0] data);
    wr_exp_t w;
    w.cyc = c; w.addr = addr; w.data = data;
    qw.push_back(w);
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] dat);
    pl_idx = idx; pl_dat = dat; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic chk_reset(input string p);
    check({p, "r0_ack"},    r0_ack,    32'd0);
    check({p, "r0_err"},    r0_err,    32'd0);
    check({p, "r0_rdata"},  r0_rdata,  32'd0);
    check({p, "r1_ack"},    r1_ack,    32'd0);
    check({p, "r1_err"},    r1_err,    32'd0);
    check({p, "r1_rdata"},  r1_rdata,  32'd0);
    check({p, "mem_we"},    mem_we,    32'd0);
    check({p, "mem_addr"},  mem_addr,  32'd0);
    check({p, "mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // Called #1 after a posedge; returns #1 after the posedge that ends the ack cycle
  task automatic r0_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
    logic seen = 1'b0;
    r0_we = we; r0_addr = addr; r0_size = size; r0_unsigned = uns; r0_wdata = wd;
    r0_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r0_ack) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    r0_req = 1'b0;
    check("r0_ack_seen", seen, 32'd1);
  endtask

  task automatic r1_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    logic seen = 1'b0;
    r1_we = we; r1_addr = addr; r1_wdata = wd;
    r1_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r1_ack) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    r1_req = 1'b0;
    check("r1_ack_seen", seen, 32'd1);
  endtask

  always @(negedge clk) begin
    if (r0_ack) begin
      if (q0.size() == 0) check("r0_unexpected_ack", 32'd1, 32'd0);
      else begin
        m_e0 = q0.pop_front();
        check("r0_ack_cycle", cyc, m_e0.cyc);
        check("r0_err", r0_err, m_e0.err);
        if (m_e0.chk) check("r0_rdata", r0_rdata, m_e0.rdata);
      end
    end
    if (r1_ack) begin
      if (q1.size() == 0) check("r1_unexpected_ack", 32'd1, 32'd0);
      else begin
        m_e1 = q1.pop_front();
        check("r1_ack_cycle", cyc, m_e1.cyc);
        check("r1_err", r1_err, m_e1.err);
        if (m_e1.chk) check("r1_rdata", r1_rdata, m_e1.rdata);
      end
    end
    if (mem_we === 1'b1) begin
      if (qw.size() == 0) check("unexpected_mem_we", 32'd1, 32'd0);
      else begin
        m_w = qw.pop_front();
        check("wr_cycle", cyc, m_w.cyc);
        check("wr_addr", mem_addr, m_w.addr);
        check("wr_data", mem_wdata, m_w.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int nack;
    rst = 1'b1;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_size = 2'b10; r0_unsigned = 1'b0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    preload(4'd3, 32'h8899AABB);
    preload(4'd4, 32'h00000000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("rst1_");
    @(posedge clk); #1;

    // Loads: signed/unsigned byte, signed half, r1 word
    c = cyc; exp_ack(0, c + 2, 1'b0, 1'b1, 32'hFFFFFF88); r0_txn(1'b0, 32'h0F, 2'b00, 1'b0, '0);
    c = cyc; exp_ack(0, c + 2, 1'b0, 1'b1, 32'h000000AA); r0_txn(1'b0, 32'h0D, 2'b00, 1'b1, '0);
    c = cyc; exp_ack(0, c + 2, 1'b0, 1'b1, 32'hFFFFAABB); r0_txn(1'b0, 32'h0C, 2'b01, 1'b0, '0);
    c = cyc; exp_ack(1, c + 2, 1'b0, 1'b1, 32'h8899AABB); r1_txn(1'b0, 32'h0C, '0);

    // Sub-word stores write once, in the cycle after ACCESS
    c = cyc; exp_wr(c + 2, 32'd3, 32'h1234AABB); exp_ack(0, c + 3, 1'b0, 1'b0, '0);
    r0_txn(1'b1, 32'h0E, 2'b01, 1'b0, 32'h00001234);
    c = cyc; exp_ack(0, c + 2, 1'b0, 1'b1, 32'h00001234); r0_txn(1'b0, 32'h0E, 2'b01, 1'b1, '0);
    c = cyc; exp_wr(c + 2, 32'd3, 32'h123455BB); exp_ack(0, c + 3, 1'b0, 1'b0, '0);
    r0_txn(1'b1, 32'h0D, 2'b00, 1'b0, 32'hFFFFFF55);
    c = cyc; exp_wr(c + 1, 32'd4, 32'hCAFEF00D); exp_ack(1, c + 2, 1'b0, 1'b0, '0);
    r1_txn(1'b1, 32'h10, 32'hCAFEF00D);
    c = cyc; exp_ack(0, c + 2, 1'b0, 1'b1, 32'hCAFEF00D); r0_txn(1'b0, 32'h10, 2'b10, 1'b0, '0);
    c = cyc; exp_ack(0, c + 2, 1'b0, 1'b1, 32'h123455BB); r0_txn(1'b0, 32'h0C, 2'b10, 1'b0, '0);

    // Misaligned and illegal-size accesses: error ack at cycle 1, no write
    c = cyc; exp_ack(0, c + 1, 1'b1, 1'b0, '0); r0_txn(1'b0, 32'h0D, 2'b10, 1'b0, '0);
    c = cyc; exp_ack(0, c + 1, 1'b1, 1'b0, '0); r0_txn(1'b1, 32'h0F, 2'b01, 1'b0, 32'h0000BEEF);
    c = cyc; exp_ack(0, c + 1, 1'b1, 1'b0, '0); r0_txn(1'b0, 32'h0C, 2'b11, 1'b0, '0);
    c = cyc; exp_ack(1, c + 1, 1'b1, 1'b0, '0); r1_txn(1'b1, 32'h0E, 32'h00000001);

    // Simultaneous requests straight after reset: r0 first
    preload(4'd3, 32'h8899AABB);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    c = cyc;
    exp_ack(0, c + 2, 1'b0, 1'b1, 32'h8899AABB);
    exp_ack(1, c + 5, 1'b0, 1'b1, 32'h8899AABB);
    fork
      r0_txn(1'b0, 32'h0C, 2'b10, 1'b0, '0);
      r1_txn(1'b0, 32'h0C, '0);
    join

    // Both hold req continuously: grants alternate r0, r1, r0, r1
    c = cyc;
    exp_ack(0, c + 2,  1'b0, 1'b1, 32'h8899AABB);
    exp_ack(1, c + 5,  1'b0, 1'b1, 32'hCAFEF00D);
    exp_ack(0, c + 8,  1'b0, 1'b1, 32'h8899AABB);
    exp_ack(1, c + 11, 1'b0, 1'b1, 32'hCAFEF00D);
    r0_we = 1'b0; r0_addr = 32'h0C; r0_size = 2'b10;
    r1_we = 1'b0; r1_addr = 32'h10;
    r0_req = 1'b1; r1_req = 1'b1;
    nack = 0;
    for (int i = 0; i < 30 && nack < 4; i++) begin
      @(negedge clk);
      nack += int'(r0_ack) + int'(r1_ack);
    end
    @(posedge clk); #1;
    r0_req = 1'b0; r1_req = 1'b0;
    check("alternating_acks", nack, 32'd4);

    // Reset during ACCESS of a byte store: abandoned, memory untouched
    r0_we = 1'b1; r0_addr = 32'h0C; r0_size = 2'b00; r0_wdata = 32'h000000EE;
    r0_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; r0_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rst2_");
    repeat (5) @(negedge clk);
    check("mem3_after_abort", mem[3], 32'h8899AABB);
    @(posedge clk); #1;
    c = cyc; exp_ack(0, c + 2, 1'b0, 1'b1, 32'h8899AABB); r0_txn(1'b0, 32'h0C, 2'b10, 1'b0, '0);

    repeat (3) @(posedge clk);
    check("r0_queue_drained", q0.size(), 32'd0);
    check("r1_queue_drained", q1.size(), 32'd0);
    check("wr_queue_drained", qw.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; data 32 bits; addresses are 32-bit byte addresses.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 r0_req  in  1  load/store unit (LSU) request; held high until r0_ack.
REQ-005 r0_we  in  1  LSU: 1=store, 0=load.
REQ-006 r0_addr  in  32  LSU byte address.
REQ-007 r0_size  in  2  LSU access size: 00=byte, 01=half, 10=word, 11=illegal.
REQ-008 r0_unsigned  in  1  LSU load extension: 1=zero-extend, 0=sign-extend.
REQ-009 r0_wdata  in  32  LSU store data, right-aligned.
REQ-010 r0_ack  out  1  LSU one-cycle completion pulse.
REQ-011 r0_err  out  1  LSU error flag, valid only while r0_ack=1.
REQ-012 r0_rdata  out  32  LSU formatted load data, valid while r0_ack=1 and held after.
REQ-013 r1_req / r1_we / r1_addr[31:0] / r1_wdata[31:0]  in  loader/debug port; word accesses only.
REQ-014 r1_ack / r1_err out 1; r1_rdata out 32  same semantics as the r0 outputs.
REQ-015 mem_addr  out  32  word index to data memory, equal to {2'b00, addr[31:2]}.
REQ-016 mem_wdata  out  32  write data to memory.
REQ-017 mem_we  out  1  memory write enable; the memory writes on the posedge where mem_we=1.
REQ-018 mem_rdata  in  32  combinational memory read data for mem_addr.

Function
REQ-019 FSM states: IDLE, ACCESS, WRITE, DONE.
REQ-020 IDLE, with any request pending: grant, latch the granted request's fields, go to ACCESS; with no request: stay in IDLE.
REQ-021 Arbitration: round-robin on last_grant. When both requesters request together, the one not granted last wins. After reset, r0 wins first.
REQ-022 Misalignment check in IDLE: a half access with addr[0]=1, a word access with addr[1:0]!=0, or r0_size=11 sets err. In that case go directly to DONE; mem_we is never asserted for that request.
REQ-023 ACCESS, load: capture formatted mem_rdata into rdata, then go to DONE.
REQ-024 ACCESS, word store: assert mem_we with mem_wdata=wdata, then go to DONE.
REQ-025 ACCESS, byte or half store: merge wdata into mem_rdata in the addressed lane(s), register the merged word, go to WRITE. mem_we=0 during ACCESS.
REQ-026 WRITE: assert mem_we with the merged word, then go to DONE.
REQ-027 DONE: pulse ack (and err if set) for the granted requester for one cycle, then go to IDLE.
REQ-028 A request still high in the IDLE cycle following DONE is treated as a new request.
REQ-029 Byte lanes are little-endian: byte k occupies bits [8k+7:8k], where k=addr[1:0]. A half access uses bits [16h+15:16h], where h=addr[1].
REQ-030 Load formatting: the selected byte or half is placed at bit 0 and extended according to r0_unsigned. Word loads pass through unchanged.
REQ-031 Latency, counted from the IDLE grant cycle (cycle 0):
- load or word store: ack at cycle 2;
- byte or half store: ack at cycle 3;
- misaligned access: ack at cycle 1.
REQ-032 mem_we=0 in IDLE and DONE.
REQ-033 mem_addr and mem_wdata hold their last values outside ACCESS and WRITE.
REQ-034 The ungranted requester's ack, err and rdata stay unchanged while the other requester is served.

Reset
REQ-035 While rst=1 at a posedge, the following are cleared: state=IDLE, last_grant=r1 (so r0 has priority next), all ack/err=0, all rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, merge register=0.
REQ-036 Reset mid-operation: the in-flight request is abandoned with no ack. A sub-word store reset in ACCESS leaves memory unchanged. The requester must re-issue the request after reset.

Verification
REQ-037 Preload mem[3]=0x8899AABB. Issue r0 load byte signed at 0x0F -> r0_rdata=0xFFFFFF88 and r0_ack at cycle 2.
REQ-038 Issue r0 store half at 0x0E with wdata=0x00001234 -> mem_we high in cycle 2 only, mem[3]=0x1234AABB, r0_ack at cycle 3. Follow with r0 load half unsigned at 0x0E -> r0_rdata=0x00001234.
REQ-039 After reset, r0 and r1 both issue word loads at 0x0C in the same cycle -> r0_ack at cycle 2, r1 granted at cycle 3, r1_ack at cycle 5, both rdata=0x8899AABB.
REQ-040 Issue r0 word load at 0x0D -> r0_ack=1 and r0_err=1 at cycle 1; mem_we never asserted.
REQ-041 Issue r0 store byte at 0x0C with wdata=0xEE; assert rst in the ACCESS cycle -> no r0_ack, mem[3] unchanged, all outputs at reset values the next cycle.
REQ-042 r0 and r1 hold req continuously for 4 requests -> grants alternate r0, r1, r0, r1.
